// File: rtl/dose_ack_monitor.sv
// Turns reminder rises into a buzzer episode, waits a bounded window for a
// debounced patient acknowledge, logs taken/missed doses and escalates repeated misses.
module dose_ack_monitor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_WINDOW      = 200,
  parameter int BEEP_PERIOD     = 10,
  parameter int MISS_LIMIT      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reminder_in,
  input  logic       ack_btn,
  input  logic       caregiver_clear,
  output logic       buzzer,
  output logic       dose_taken,
  output logic       dose_missed,
  output logic [3:0] missed_count,
  output logic       caregiver_alert
);

  localparam logic [7:0]  DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] WIN_LAST  = 16'(ACK_WINDOW - 1);
  localparam logic [7:0]  BEEP_LAST = 8'(BEEP_PERIOD - 1);
  localparam logic [3:0]  LIMIT     = 4'(MISS_LIMIT);

  typedef enum logic {IDLE, ALERT} state_t;

  logic        sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [7:0]  deb_cnt_q;
  logic        rem_q, rem_prev_q, pend_q;
  state_t      state_q;
  logic [15:0] win_q;
  logic [7:0]  beep_q;
  logic        phase_q, taken_q, missed_q;
  logic        alert_q, alert_d;
  logic [3:0]  total_q, total_d, streak_q, streak_d;

  logic       ack_ev, rise, win_done, leaving, miss_ev, reach;
  logic [3:0] streak_inc, total_inc;

  // Raw button crosses domains through two flops, then must hold a new level
  // for DEBOUNCE_CYCLES consecutive samples before the debounced level follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      rem_q      <= 1'b0;
      rem_prev_q <= 1'b0;
    end else begin
      sync1_q    <= ack_btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      rem_q      <= reminder_in;
      rem_prev_q <= rem_q;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 8'd1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign ack_ev     = deb_q & ~deb_prev_q;
  assign rise       = rem_q & ~rem_prev_q;
  assign win_done   = (win_q == WIN_LAST);
  assign leaving    = (state_q == ALERT) && (ack_ev || win_done);
  assign miss_ev    = (state_q == ALERT) && !ack_ev && win_done;
  assign streak_inc = (streak_q == 4'd15) ? streak_q : streak_q + 4'd1;
  assign total_inc  = (total_q == 4'd15) ? total_q : total_q + 4'd1;
  assign reach      = miss_ev && (streak_inc == LIMIT);

  // A clear coinciding with a limit-reaching miss loses to the set, and the
  // streak restarts at one because that miss still counts.
  always_comb begin
    streak_d = streak_q;
    alert_d  = alert_q;
    total_d  = total_q;
    if (caregiver_clear)
      streak_d = miss_ev ? 4'd1 : 4'd0;
    else if (miss_ev)
      streak_d = streak_inc;
    else if ((state_q == ALERT) && ack_ev)
      streak_d = 4'd0;
    if (reach)
      alert_d = 1'b1;
    else if (caregiver_clear)
      alert_d = 1'b0;
    if (miss_ev)
      total_d = total_inc;
  end

  // Episode FSM; a rise landing on the exit cycle is parked in pend_q so the
  // next episode opens one cycle later instead of being dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      beep_q   <= '0;
      phase_q  <= 1'b0;
      taken_q  <= 1'b0;
      missed_q <= 1'b0;
      pend_q   <= 1'b0;
      alert_q  <= 1'b0;
      total_q  <= '0;
      streak_q <= '0;
    end else begin
      taken_q  <= 1'b0;
      missed_q <= 1'b0;
      pend_q   <= leaving && rise;
      alert_q  <= alert_d;
      total_q  <= total_d;
      streak_q <= streak_d;
      case (state_q)
        IDLE: begin
          phase_q <= 1'b0;
          if (rise || pend_q) begin
            state_q <= ALERT;
            win_q   <= '0;
            beep_q  <= '0;
            phase_q <= 1'b1;
          end
        end
        ALERT: begin
          win_q <= win_q + 16'd1;
          if (beep_q == BEEP_LAST) begin
            beep_q  <= '0;
            phase_q <= ~phase_q;
          end else begin
            beep_q <= beep_q + 8'd1;
          end
          if (ack_ev) begin
            taken_q <= 1'b1;
            state_q <= IDLE;
            phase_q <= 1'b0;
          end else if (win_done) begin
            missed_q <= 1'b1;
            state_q  <= IDLE;
            phase_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buzzer          = phase_q;
  assign dose_taken      = taken_q;
  assign dose_missed     = missed_q;
  assign missed_count    = total_q;
  assign caregiver_alert = alert_q;

endmodule

// File: doc/dose_ack_monitor.md
# dose_ack_monitor

Downstream consumer of the medicine reminder output: turns each reminder assertion into an audible buzzer pattern and waits a bounded window for the patient's acknowledge button. Each dose is logged as taken or missed. Consecutive misses escalate to a sticky caregiver alert. The block sits between the reminder timer and the front-panel buzzer, button and caregiver-alert outputs.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a button level change (range 1..255).
- ACK_WINDOW, 200: cycles an episode stays open awaiting acknowledge (range 2..65535).
- BEEP_PERIOD, 10: buzzer half-period in cycles (range 1..255).
- MISS_LIMIT, 2: consecutive misses that raise caregiver_alert (range 1..15).
- clk  input  1  system clock, single domain.
- reset  input  1  asynchronous, active-high; clears all state.
- reminder_in  input  1  reminder level from the reminder timer, same clock domain; a rising edge opens an episode.
- ack_btn  input  1  raw patient button, asynchronous; synchronized and debounced internally.
- caregiver_clear  input  1  synchronous pulse that clears caregiver_alert and the consecutive-miss count.
- buzzer  output  1  beep drive, active only in ALERT.
- dose_taken  output  1  one-cycle pulse on an accepted acknowledge.
- dose_missed  output  1  one-cycle pulse on window expiry.
- missed_count  output  4  total misses since reset, saturates at 15.
- caregiver_alert  output  1  sticky escalation flag.

## Operation
- Reset values: buzzer=0, dose_taken=0, dose_missed=0, missed_count=0, caregiver_alert=0, state=IDLE. The synchronizer and debounced level reset to 0. Internal counters reset to 0.
- Button path: 2-FF synchronizer, then a debouncer. The debounced level flips after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. A mismatch lasting fewer cycles resets the debounce counter. An ack event is a rising edge of the debounced level.
- Reminder edge: reminder_in is registered. A rise is reminder_in=1 with the previous sample=0.
- IDLE: buzzer=0. On a reminder rise, go to ALERT, clear the window counter, clear the beep counter and set the beep phase to 1. Ack events in IDLE are discarded.
- ALERT:
  - buzzer equals the beep phase. The phase toggles each time the beep counter reaches BEEP_PERIOD-1; the beep counter then wraps to 0.
  - The window counter increments every cycle.
  - Ack event: pulse dose_taken, clear the consecutive-miss count, go to IDLE.
  - Else, if the window counter = ACK_WINDOW-1: pulse dose_missed, increment missed_count (saturating at 15), increment the consecutive-miss count (saturating at 15), go to IDLE.
  - reminder_in falling or rising again during ALERT is ignored; no restart, no second episode.
- Escalation: caregiver_alert sets in the cycle the consecutive-miss count reaches MISS_LIMIT and stays set until caregiver_clear.
- caregiver_clear clears caregiver_alert and the consecutive-miss count. If it coincides with a miss that would reach MISS_LIMIT, the set wins and the count becomes 1.
- A reminder rise in the same cycle the FSM returns to IDLE is not lost: the edge register holds the pending rise for one cycle.

## Timing
- All outputs are registered.
- Reminder rise sampled at edge N: buzzer=1 from edge N+1.
- Raw ack_btn held high from edge N: synchronized high at N+2, debounced high at N+2+DEBOUNCE_CYCLES, dose_taken high for the cycle after that edge, buzzer=0 on the same edge.
- Miss: dose_missed high for exactly one cycle, ACK_WINDOW cycles after buzzer first asserts. missed_count and caregiver_alert update on the same edge.
- Ack event and window expiry in the same cycle: ack wins, so dose_taken fires and no miss is logged.
- reset asserted mid-episode: all outputs drop to reset values immediately, with no taken or missed pulse. The next episode requires a fresh reminder rise after reset deasserts.

## Test plan
- Defaults; reminder rise, button pressed 50 cycles later and held 10 cycles -> buzzer toggles every 10 cycles; dose_taken pulses once at press+7; missed_count=0.
- Reminder rise, no press -> dose_missed at cycle 200 of ALERT; missed_count=1; caregiver_alert=0.
- Two consecutive missed episodes -> caregiver_alert=1 at the second miss; caregiver_clear -> 0; a taken dose in between resets the streak, so no alert.
- Button glitch high for 3 cycles during ALERT -> no dose_taken; glitch for 4+ stable cycles -> accepted.
- Ack reaching the debouncer in the final window cycle -> dose_taken only; 16 misses -> missed_count stays 15.
- reset asserted at cycle 100 of ALERT -> buzzer=0, no pulses; a second reminder rise during ALERT is ignored.
